// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: phase-select encoding, lane-count encodings, default dummy length.
// Lane counts are carried as a shift amount so phase lengths become a simple right shift.
package qspi_pkg;

    typedef enum logic [1:0] {
        CNT_CMD   = 2'b00,
        CNT_ADDR  = 2'b01,
        CNT_DUMMY = 2'b10,
        CNT_DATA  = 2'b11
    } cnt_lim_e;

    localparam logic [1:0] LANE_SHIFT_1 = 2'd0;
    localparam logic [1:0] LANE_SHIFT_2 = 2'd1;
    localparam logic [1:0] LANE_SHIFT_4 = 2'd2;

    localparam int DEFAULT_DUMMY_CYC = 8;

endpackage

// File: rtl/qspi_phase_counter.sv
// Phase-length counter: decodes N from the phase select and lane mode, flags terminal count.
// count_done is combinational from the registered count (zero added latency); no backpressure.
module qspi_phase_counter
    import qspi_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DUMMY_CYC = DEFAULT_DUMMY_CYC
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [1:0] i_lim,
    input  logic       i_addr_4b,
    input  logic [1:0] i_lane_shift,
    output logic       o_count_done
);

    localparam logic [7:0] DATA_LEN  = 8'(DATA_W);
    localparam logic [7:0] DUMMY_LEN = 8'(DUMMY_CYC);

    logic [7:0] r_cnt;
    logic [7:0] w_n;

    // N is decoded live every cycle; a mid-phase select change compares against the new N.
    always_comb begin
        w_n = 8'd8;
        case (cnt_lim_e'(i_lim))
            CNT_CMD:   w_n = 8'd8;
            CNT_ADDR:  w_n = (i_addr_4b ? 8'd32 : 8'd24) >> i_lane_shift;
            CNT_DUMMY: w_n = DUMMY_LEN;
            CNT_DATA:  w_n = DATA_LEN >> i_lane_shift;
            default:   w_n = 8'd8;
        endcase
    end

    assign o_count_done = i_start && (r_cnt == (w_n - 8'd1));

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (!i_start || o_count_done) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/qspi_rx_counter_path.sv
// QSPI rx datapath: phase counter, IO-line sampler and burst word counter (QSPI_DUAL_IO_EN enables dual lane).
// Sampler/burst outputs are registered (1 cycle); count_done/burst_comp decode registered state; no backpressure.
module qspi_rx_counter_path
    import qspi_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 8,
    parameter int DUMMY_CYC = DEFAULT_DUMMY_CYC
) (
    input  logic               sclk,
    input  logic               rst_n,
    input  logic               cs_n_in,
    input  logic               start_count_in,
    input  logic [1:0]         set_count_lim_in,
    input  logic               addr_of_4B_in,
    input  logic               use_1_io_lines_in,
    input  logic               use_2_io_lines_in,
    input  logic               use_4_io_lines_in,
    input  logic               data_sample_reg_en_in,
    input  logic               sel_sample_1_line_in,
    input  logic [3:0]         io_in,
    input  logic               burst_count_en_in,
    input  logic [BURST_W-1:0] burst_len_in,
    output logic               count_done_out,
    output logic               burst_comp_out,
    output logic [DATA_W-1:0]  rx_data_out
);

    logic [1:0]         w_mode_shift;
    logic [1:0]         w_smp_shift;
    logic [DATA_W-1:0]  r_rx;
    logic [BURST_W-1:0] r_bcnt;
    logic [BURST_W-1:0] w_len_min;
    logic               w_unused_mode;

    // Single-lane is the fallthrough mode, so its own select carries no information.
`ifdef QSPI_DUAL_IO_EN
    assign w_mode_shift  = use_4_io_lines_in ? LANE_SHIFT_4 :
                           use_2_io_lines_in ? LANE_SHIFT_2 : LANE_SHIFT_1;
    assign w_unused_mode = use_1_io_lines_in;
`else
    assign w_mode_shift  = use_4_io_lines_in ? LANE_SHIFT_4 : LANE_SHIFT_1;
    assign w_unused_mode = use_1_io_lines_in ^ use_2_io_lines_in;
`endif

    assign w_smp_shift = sel_sample_1_line_in ? LANE_SHIFT_1 : w_mode_shift;

    qspi_phase_counter #(
        .DATA_W    (DATA_W),
        .DUMMY_CYC (DUMMY_CYC)
    ) u_phase_cnt (
        .sclk         (sclk),
        .rst_n        (rst_n),
        .i_start      (start_count_in),
        .i_lim        (set_count_lim_in),
        .i_addr_4b    (addr_of_4B_in),
        .i_lane_shift (w_mode_shift),
        .o_count_done (count_done_out)
    );

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx <= '0;
        end else if (data_sample_reg_en_in) begin
            case (w_smp_shift)
                LANE_SHIFT_4: r_rx <= {r_rx[DATA_W-5:0], io_in};
`ifdef QSPI_DUAL_IO_EN
                LANE_SHIFT_2: r_rx <= {r_rx[DATA_W-3:0], io_in[1:0]};
`endif
                default:      r_rx <= {r_rx[DATA_W-2:0], io_in[1]};
            endcase
        end
    end

    assign rx_data_out = r_rx;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt <= '0;
        end else if (cs_n_in) begin
            r_bcnt <= '0;
        end else if (burst_count_en_in && (r_bcnt != {BURST_W{1'b1}})) begin
            r_bcnt <= r_bcnt + BURST_W'(1);
        end
    end

    // A zero burst length behaves as a single-word burst.
    assign w_len_min      = (burst_len_in == '0) ? BURST_W'(1) : burst_len_in;
    assign burst_comp_out = (r_bcnt >= w_len_min);

endmodule

// File: tb/tb_qspi_rx_counter_path.sv
// Bench for qspi_rx_counter_path: directed phase/sampler/burst scenarios plus randomized traffic vs a behavioural model.
module tb_qspi_rx_counter_path;

    localparam int DATA_W  = 32;
    localparam int BURST_W = 8;
    localparam int DUMMY   = 6;
`ifdef QSPI_DUAL_IO_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic               sclk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cs_n = 1'b1;
    logic               start = 1'b0;
    logic [1:0]         lim = 2'd0;
    logic               a4 = 1'b0;
    logic               u1 = 1'b1;
    logic               u2 = 1'b0;
    logic               u4 = 1'b0;
    logic               en = 1'b0;
    logic               sel = 1'b0;
    logic [3:0]         io = 4'd0;
    logic               ben = 1'b0;
    logic [BURST_W-1:0] blen = '0;
    logic               done_out;
    logic               comp_out;
    logic [DATA_W-1:0]  rx_out;

    int checks = 0;
    int errors = 0;

    int          m_el = 0;
    logic [31:0] m_rx = '0;
    int          m_b  = 0;

    qspi_rx_counter_path #(
        .DATA_W    (DATA_W),
        .BURST_W   (BURST_W),
        .DUMMY_CYC (DUMMY)
    ) dut (
        .sclk                  (sclk),
        .rst_n                 (rst_n),
        .cs_n_in               (cs_n),
        .start_count_in        (start),
        .set_count_lim_in      (lim),
        .addr_of_4B_in         (a4),
        .use_1_io_lines_in     (u1),
        .use_2_io_lines_in     (u2),
        .use_4_io_lines_in     (u4),
        .data_sample_reg_en_in (en),
        .sel_sample_1_line_in  (sel),
        .io_in                 (io),
        .burst_count_en_in     (ben),
        .burst_len_in          (blen),
        .count_done_out        (done_out),
        .burst_comp_out        (comp_out),
        .rx_data_out           (rx_out)
    );

    always #5 sclk = ~sclk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int mode_lanes();
        if (u4) return 4;
        if (u2 && DUAL) return 2;
        return 1;
    endfunction

    function automatic int phase_len();
        case (lim)
            2'd0:    return 8;
            2'd1:    return (a4 ? 32 : 24) / mode_lanes();
            2'd2:    return DUMMY;
            default: return DATA_W / mode_lanes();
        endcase
    endfunction

    function automatic bit exp_done();
        return start && (m_el == phase_len() - 1);
    endfunction

    function automatic bit exp_comp();
        int target;
        target = (blen == 0) ? 1 : int'(blen);
        return m_b >= target;
    endfunction

    task automatic model_reset();
        m_el = 0;
        m_rx = '0;
        m_b  = 0;
    endtask

    task automatic model_step();
        bit dn;
        int ls;
        int bits;
        dn = exp_done();
        if (!start || dn) m_el = 0;
        else              m_el = (m_el + 1) % 256;
        if (en) begin
            ls = sel ? 1 : mode_lanes();
            if (ls == 4)      bits = int'(io);
            else if (ls == 2) bits = int'(io) % 4;
            else              bits = (int'(io) / 2) % 2;
            m_rx = (m_rx << ls) | 32'(bits);
        end
        if (cs_n)                 m_b = 0;
        else if (ben && m_b < 255) m_b = m_b + 1;
    endtask

    // Called right after a falling edge with inputs already driven.
    task automatic cycle(output bit d);
        #1;
        d = done_out;
        check("count_done", 32'(done_out), 32'(exp_done()));
        check("burst_comp", 32'(comp_out), 32'(exp_comp()));
        check("rx_data", rx_out, m_rx);
        @(posedge sclk);
        model_step();
        @(negedge sclk);
    endtask

    task automatic idle_inputs();
        cs_n = 1'b1; start = 1'b0; lim = 2'd0; a4 = 1'b0;
        u1 = 1'b1; u2 = 1'b0; u4 = 1'b0; en = 1'b0; sel = 1'b0;
        io = 4'd0; ben = 1'b0; blen = '0;
    endtask

    initial begin
        bit          d;
        int          first_k;
        int          second_k;
        int          done_k;
        logic [31:0] pat;

        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge sclk);
        #1;
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_comp", 32'(comp_out), 32'd0);
        check("rst_rx", rx_out, 32'd0);
        @(negedge sclk);
        rst_n = 1'b1;

        // Quad, 3-byte address: cmd phase then address phase back to back.
        u4 = 1'b1; start = 1'b1; first_k = 0; second_k = 0;
        for (int k = 1; k <= 14; k++) begin
            lim = (k <= 8) ? 2'd0 : 2'd1;
            cycle(d);
            if (d) begin
                if (first_k == 0) first_k = k;
                else if (second_k == 0) second_k = k;
            end
        end
        check("quad_cmd_done_cyc", first_k, 8);
        check("quad_addr_done_cyc", second_k, 14);
        start = 1'b0;
        cycle(d);

        // Single-lane data word on io1, other lines carry noise.
        u4 = 1'b0; lim = 2'd3; start = 1'b1; en = 1'b1; done_k = 0;
        pat = 32'hA5A5_1234;
        for (int k = 0; k < 32; k++) begin
            io = 4'($urandom_range(0, 15) & 4'hD) | 4'(pat[31-k] << 1);
            cycle(d);
            if (d && done_k == 0) done_k = k + 1;
        end
        start = 1'b0; en = 1'b0;
        cycle(d);
        check("single_done_cyc", done_k, 32);
        check("single_word", rx_out, 32'hA5A5_1234);

        // Quad data word.
        u4 = 1'b1; lim = 2'd3; start = 1'b1; en = 1'b1; done_k = 0;
        pat = 32'hDEAD_BEEF;
        for (int k = 0; k < 8; k++) begin
            io = 4'((pat >> (28 - 4 * k)) & 32'hF);
            cycle(d);
            if (d && done_k == 0) done_k = k + 1;
        end
        start = 1'b0; en = 1'b0;
        cycle(d);
        check("quad_done_cyc", done_k, 8);
        check("quad_word", rx_out, 32'hDEAD_BEEF);

        // Burst length 4, then cs_n clear, then zero length.
        cs_n = 1'b0; blen = 8'd4;
        for (int i = 0; i < 4; i++) begin
            ben = 1'b1;
            cycle(d);
            ben = 1'b0;
            check("burst_after_pulse", 32'(comp_out), (i == 3) ? 32'd1 : 32'd0);
            cycle(d);
        end
        cs_n = 1'b1;
        cycle(d);
        check("burst_cleared", 32'(comp_out), 32'd0);
        cs_n = 1'b0; blen = 8'd0; ben = 1'b1;
        cycle(d);
        ben = 1'b0;
        check("burst_len0_one_pulse", 32'(comp_out), 32'd1);
        cs_n = 1'b1; ben = 1'b1;
        cycle(d);
        cs_n = 1'b0; ben = 1'b0;
        check("burst_clear_wins", 32'(comp_out), 32'd0);
        cycle(d);

        // Dummy phase interrupted at cycle 3, then a full restart.
        lim = 2'd2; start = 1'b1; done_k = 0;
        for (int k = 1; k <= 3; k++) begin
            cycle(d);
            if (d) done_k = k;
        end
        check("dummy_no_early_done", done_k, 0);
        start = 1'b0;
        cycle(d);
        start = 1'b1;
        for (int k = 1; k <= DUMMY; k++) begin
            cycle(d);
            if (d && done_k == 0) done_k = k;
        end
        check("dummy_restart_done_cyc", done_k, DUMMY);
        start = 1'b0;
        cycle(d);

        // Reset in the middle of a single-lane data phase.
        u4 = 1'b0; lim = 2'd3; start = 1'b1; en = 1'b1; cs_n = 1'b0; blen = 8'd1; ben = 1'b1;
        for (int k = 0; k < 10; k++) begin
            io = 4'($urandom_range(0, 15));
            cycle(d);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_done", 32'(done_out), 32'd0);
        check("midrst_comp", 32'(comp_out), 32'd0);
        check("midrst_rx", rx_out, 32'd0);
        model_reset();
        @(negedge sclk);
        idle_inputs();
        @(negedge sclk);
        rst_n = 1'b1;
        u4 = 1'b1; lim = 2'd3; start = 1'b1; done_k = 0;
        for (int k = 1; k <= 8; k++) begin
            cycle(d);
            if (d && done_k == 0) done_k = k;
        end
        check("post_rst_done_cyc", done_k, 8);
        start = 1'b0;
        cycle(d);

        // Randomized traffic, including mid-phase select changes.
        cs_n = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            start = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) lim = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) begin
                a4 = 1'($urandom_range(0, 1));
                u1 = 1'($urandom_range(0, 1));
                u2 = 1'($urandom_range(0, 1));
                u4 = 1'($urandom_range(0, 1));
            end
            en   = 1'($urandom_range(0, 1));
            sel  = ($urandom_range(0, 3) == 0);
            io   = 4'($urandom_range(0, 15));
            ben  = 1'($urandom_range(0, 1));
            cs_n = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 15) == 0) blen = 8'($urandom_range(0, 7));
            cycle(d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
